// File: rtl/instr_fetch_arbiter_pkg.sv
// Shared types and sizes for the instruction fetch arbiter and its peers.
// Constants only; no logic, latency or backpressure of its own.
package instr_fetch_arbiter_pkg;

    localparam int NUM_SM = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUN,
        ST_DRAIN
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_arbiter_if.sv
// Host, FSM-fetch and regfile signals of the fetch arbiter in one bundle.
// slave = arbiter view; master = host/FSM/regfile environment view.
interface instr_fetch_arbiter_if #(
    parameter int NUM_SM = instr_fetch_arbiter_pkg::NUM_SM,
    parameter int ADDR_W = instr_fetch_arbiter_pkg::ADDR_W,
    parameter int DATA_W = instr_fetch_arbiter_pkg::DATA_W
);
    logic              host_halt;
    logic              halted;
    logic              host_wr_req;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_ack;
    logic [NUM_SM-1:0] sm_req;
    logic [ADDR_W-1:0] sm_addr [NUM_SM];
    logic [NUM_SM-1:0] sm_gnt;
    logic [NUM_SM-1:0] sm_rvalid;
    logic [DATA_W-1:0] sm_rdata;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] instr_in;
    logic              write_en;

    modport slave (
        input  host_halt, host_wr_req, host_wr_addr, host_wr_data,
        input  sm_req, sm_addr, instr_out,
        output halted, host_wr_ack, sm_gnt, sm_rvalid, sm_rdata,
        output read_addr, write_addr, instr_in, write_en
    );

    modport master (
        output host_halt, host_wr_req, host_wr_addr, host_wr_data,
        output sm_req, sm_addr, instr_out,
        input  halted, host_wr_ack, sm_gnt, sm_rvalid, sm_rdata,
        input  read_addr, write_addr, instr_in, write_en
    );

endinterface

// File: rtl/instr_fetch_arbiter_rr_arbiter.sv
// Round-robin one-hot grant over the FSM fetch requests; grant is combinational.
// Unserved requesters simply stay asserted; pointer moves past each winner.
module instr_fetch_arbiter_rr_arbiter
    import instr_fetch_arbiter_pkg::*;
#(
    parameter  int N  = NUM_SM,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_any;
    int            w_cand;

    // Scan from the pointer upward, wrapping; first requester found wins.
    always_comb begin
        w_gnt  = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        w_cand = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(r_ptr) + k) % N;
            if (i_en && !w_any && i_req[w_cand[IW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_cand[IW-1:0];
            end
        end
        if (w_any) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Shares the regfile read port among the FSMs and gates host program writes behind halt/drain.
// Grant same cycle as request, rvalid/rdata one cycle later; host writes wait (no ack) until HALTED.
module instr_fetch_arbiter #(
    parameter int NUM_SM = instr_fetch_arbiter_pkg::NUM_SM,
    parameter int ADDR_W = instr_fetch_arbiter_pkg::ADDR_W,
    parameter int DATA_W = instr_fetch_arbiter_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_arbiter_if.slave bus
);
    import instr_fetch_arbiter_pkg::*;

    localparam int IW = idx_w(NUM_SM);

    arb_state_t        r_state;
    logic [NUM_SM-1:0] r_rvalid;
    logic [ADDR_W-1:0] r_last_addr;
    logic [NUM_SM-1:0] w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_run;
    logic              w_wr_ok;

    assign w_run   = rst && (r_state == ST_RUN);
    assign w_wr_ok = rst && (r_state == ST_HALTED) && bus.host_wr_req;

    instr_fetch_arbiter_rr_arbiter #(
        .N (NUM_SM)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_run),
        .i_req (bus.sm_req),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Address is steered straight through on a grant so the regfile answers next cycle.
    assign bus.sm_gnt     = w_gnt;
    assign bus.read_addr  = w_any ? bus.sm_addr[w_idx] : r_last_addr;
    assign bus.sm_rvalid  = r_rvalid;
    assign bus.sm_rdata   = (|r_rvalid) ? bus.instr_out : {DATA_W{1'b0}};

    assign bus.host_wr_ack = w_wr_ok;
    assign bus.write_en    = w_wr_ok;
    assign bus.write_addr  = bus.host_wr_addr;
    assign bus.instr_in    = bus.host_wr_data;
    assign bus.halted      = (r_state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_HALTED;
            r_rvalid    <= '0;
            r_last_addr <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_any) begin
                r_last_addr <= bus.sm_addr[w_idx];
            end
            // DRAIN lasts exactly one cycle so the final grant's data is delivered first.
            case (r_state)
                ST_HALTED: r_state <= bus.host_halt ? ST_HALTED : ST_RUN;
                ST_RUN:    r_state <= bus.host_halt ? ST_DRAIN : ST_RUN;
                ST_DRAIN:  r_state <= ST_HALTED;
                default:   r_state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Bench for instr_fetch_arbiter: directed scenarios then random traffic, a reference
// model predicting grants/acks, and a scoreboard matching every readback.
module tb_instr_fetch_arbiter;
    import instr_fetch_arbiter_pkg::*;

    localparam int N  = NUM_SM;
    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_arbiter_if bus ();

    instr_fetch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment regfile: synchronous read, write on write_en.
    logic [DW-1:0] rf_mem [DEPTH];
    always @(posedge clk) begin
        bus.instr_out <= rf_mem[bus.read_addr];
        if (bus.write_en) rf_mem[bus.write_addr] <= bus.instr_in;
    end

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            sm;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    // Reference model: 0 = halted, 1 = running, 2 = draining.
    int            m_state;
    int            m_ptr;
    logic [AW-1:0] m_last;
    logic [DW-1:0] m_mem [DEPTH];

    bit            d_rst, d_halt, d_wr;
    logic [AW-1:0] d_wa;
    logic [DW-1:0] d_wd;
    logic [N-1:0]  d_req;
    logic [AW-1:0] d_addr [N];

    task automatic step();
        int            win;
        logic [N-1:0]  eg;
        logic          eack;
        logic [AW-1:0] era;
        logic          eh;
        @(posedge clk);
        #1;
        cyc++;
        rst              = d_rst;
        bus.host_halt    = d_halt;
        bus.host_wr_req  = d_wr;
        bus.host_wr_addr = d_wa;
        bus.host_wr_data = d_wd;
        bus.sm_req       = d_req;
        for (int i = 0; i < N; i++) bus.sm_addr[i] = d_addr[i];

        win  = -1;
        eack = 1'b0;
        eh   = (m_state == 0);
        if (d_rst) begin
            if (m_state == 0) eack = d_wr;
            else if (m_state == 1)
                for (int k = 0; k < N; k++)
                    if (win < 0 && d_req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        era = (win >= 0) ? d_addr[win] : m_last;

        #3;
        chk("gnt", 32'(bus.sm_gnt), 32'(eg));
        chk("halted", 32'(bus.halted), 32'(eh));
        chk("wr_ack", 32'(bus.host_wr_ack), 32'(eack));
        chk("write_en", 32'(bus.write_en), 32'(eack));
        chk("read_addr", 32'(bus.read_addr), 32'(era));
        if (eack) begin
            chk("write_addr", 32'(bus.write_addr), 32'(d_wa));
            chk("write_data", 32'(bus.instr_in), 32'(d_wd));
        end
        if (win >= 0) q.push_back('{sm: win, data: m_mem[d_addr[win]], due: cyc + 1});

        if (!d_rst) begin
            m_state = 0;
            m_ptr   = 0;
            m_last  = '0;
        end else begin
            if (eack) m_mem[d_wa] = d_wd;
            if (win >= 0) begin
                m_ptr  = (win + 1) % N;
                m_last = d_addr[win];
            end
            case (m_state)
                0:       m_state = d_halt ? 0 : 1;
                1:       m_state = d_halt ? 2 : 1;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic go(input bit r, input bit h, input bit w, input int wa, input int wd,
                      input logic [N-1:0] req);
        logic [31:0] t;
        t      = 32'(wd);
        d_rst  = r;
        d_halt = h;
        d_wr   = w;
        d_wa   = AW'(wa);
        d_wd   = t[DW-1:0];
        d_req  = req;
        step();
    endtask

    // Monitor: every readback must match the oldest prediction, in the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (bus.sm_rvalid !== '0) begin
                    if (q.size() == 0) begin
                        chk("rvalid_spurious", 32'(bus.sm_rvalid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rvalid_id", 32'(bus.sm_rvalid), 32'(1) << e.sm);
                        chk("rdata", 32'(bus.sm_rdata), 32'(e.data));
                        chk("rvalid_cycle", 32'(cyc), 32'(e.due));
                    end
                end else begin
                    chk("rdata_idle", 32'(bus.sm_rdata), 32'd0);
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        chk("rvalid_missing", 32'(bus.sm_rvalid), 32'(1) << q[0].sm);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rf_mem[i] = '0;
            m_mem[i]  = '0;
        end
        for (int i = 0; i < N; i++) begin
            bus.sm_addr[i] = '0;
            d_addr[i]      = '0;
        end
        rst              = 1'b0;
        bus.host_halt    = 1'b1;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        bus.sm_req       = '0;
        repeat (2) @(posedge clk);
        m_state = 0;
        m_ptr   = 0;
        m_last  = '0;
        started = 1'b1;

        // Reset state, program load, first fetch.
        go(1, 1, 0, 0, 0, 4'b0000);
        go(1, 1, 1, 3, 'hA001, 4'b0000);
        for (int i = 0; i < N; i++) go(1, 1, 1, 8 + i, 'hB000 + i, 4'b0000);
        d_addr[0] = 5'd3;
        go(1, 0, 0, 0, 0, 4'b0001);
        go(1, 0, 0, 0, 0, 4'b0001);
        go(1, 0, 0, 0, 0, 4'b0000);

        // Fresh pointer, all four requesting for 8 cycles.
        go(0, 1, 0, 0, 0, 4'b0000);
        go(1, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < N; i++) d_addr[i] = AW'(8 + i);
        repeat (8) go(1, 0, 0, 0, 0, 4'b1111);

        // Move pointer to 1, then FSM2/FSM0 alternate.
        go(1, 0, 0, 0, 0, 4'b0001);
        repeat (3) go(1, 0, 0, 0, 0, 4'b0101);

        // Halt with FSM1 requesting and a write held from the same cycle.
        repeat (3) go(1, 1, 1, 7, 'hC0DE, 4'b0010);
        go(1, 0, 1, 5, 'h1234, 4'b0000);
        repeat (5) go(1, 0, 1, 6, 'h5555, 4'b0000);

        // Reset while requests are pending.
        go(1, 0, 0, 0, 0, 4'b1111);
        go(0, 0, 0, 0, 0, 4'b1111);
        go(1, 0, 0, 0, 0, 4'b1111);
        go(1, 0, 0, 0, 0, 4'b1111);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) d_addr[i] = AW'($urandom_range(0, DEPTH - 1));
            go($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 65535)),
               N'($urandom_range(0, (1 << N) - 1)));
        end

        repeat (3) go(1, 1, 0, 0, 0, 4'b0000);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_arbiter.md
# instr_fetch_arbiter

Shares the single read port of `instruction_regfile` among the four PIO state machines (`fsm` instances) using round-robin arbitration. Gates host program loading through the regfile write port behind a halt/drain handshake, so a program is never rewritten while a fetch is in flight. Sits between the host bus, the four FSM fetch interfaces and `instruction_regfile`.

## Interface
Parameters:
- `NUM_SM`, 4: number of requesting state machines.
- `ADDR_W`, 5: instruction address width (32 entries).
- `DATA_W`, 16: instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `host_halt`  in  1  request to stop fetching and permit program writes.
- `halted`  out  1  high in HALTED state.
- `host_wr_req`  in  1  host write request.
- `host_wr_addr`  in  `ADDR_W`  write address.
- `host_wr_data`  in  `DATA_W`  instruction to write.
- `host_wr_ack`  out  1  write accepted this cycle.
- `sm_req`  in  `NUM_SM`  per-FSM fetch request.
- `sm_addr`  in  `ADDR_W` x `NUM_SM`  per-FSM fetch address (unpacked array).
- `sm_gnt`  out  `NUM_SM`  one-hot fetch grant, same cycle as the request.
- `sm_rvalid`  out  `NUM_SM`  one-hot pulse: `sm_rdata` belongs to this FSM.
- `sm_rdata`  out  `DATA_W`  fetched instruction, shared by all FSMs.
- `read_addr`  out  `ADDR_W`  to the regfile read port.
- `instr_out`  in  `DATA_W`  from the regfile; valid one cycle after `read_addr`.
- `write_addr`, `instr_in`, `write_en`  out  `ADDR_W`/`DATA_W`/1  to the regfile write port.

## Operation
- States: HALTED, RUN, DRAIN.
  - HALTED: no grants. `host_wr_req` gives `write_en`=1, `write_addr`=`host_wr_addr`, `instr_in`=`host_wr_data` and `host_wr_ack`=1 in the same cycle.
  - HALTED with `host_halt`=0 moves to RUN on the next edge. Writes are still accepted in that cycle.
  - RUN: arbitration active. `host_wr_ack` and `write_en` are held at 0; the host keeps `host_wr_req` asserted until acked.
  - RUN with `host_halt`=1 moves to DRAIN. A grant is still issued in that cycle.
  - DRAIN: no grants, no writes. Delivers any outstanding `sm_rvalid`. Moves to HALTED unconditionally after 1 cycle, even if `host_halt` has dropped.
- Arbitration:
  - Pointer `rr_ptr` (0..NUM_SM-1). The winner is the first set bit of `sm_req` scanning `rr_ptr`, `rr_ptr`+1, ... modulo `NUM_SM`.
  - At most one grant per cycle. `read_addr` = `sm_addr[winner]`.
  - When no requester wins, `read_addr` holds its last value.
  - After a grant to i, `rr_ptr` = (i+1) mod `NUM_SM`. Without a grant, `rr_ptr` is unchanged.
- Readback: `sm_rvalid[i]` is registered from `sm_gnt[i]`. `sm_rdata` = `instr_out` whenever any `sm_rvalid` bit is high, else 0.
- An FSM not granted keeps `sm_req` high. Request and grant are a same-cycle valid/ready pair.

## Timing
- Reset (`rst`=0 at an edge):
  - State HALTED, `halted`=1, `rr_ptr`=0.
  - `sm_rvalid`=0 and `read_addr`=0.
  - Outputs are also forced to 0 while reset is held: `sm_gnt`=0, `host_wr_ack`=0, `write_en`=0.
- Reset mid-fetch: a pending `sm_rvalid` is discarded.
- Fetch latency: grant in cycle N, then `sm_rvalid`/`sm_rdata` in cycle N+1.
  - Back-to-back grants give one instruction per cycle.
- Halt latency: `host_halt` sampled in RUN at N, DRAIN at N+1, `halted`=1 at N+2. The first write can be acked at N+2.
- Simultaneous `host_halt` and requests in RUN: the request is granted, and its rvalid arrives during DRAIN.

## Structure
- `types.svh` holds:
  - the `arb_state_t` enum (HALTED, RUN, DRAIN);
  - a `NUM_SM` localparam shared with the FSM output arbitration.
- The sub-module `rr_arbiter` holds `rr_ptr` and produces the one-hot grant from `sm_req` and the pointer. The state machine, write gating and readback pipeline stay in `instr_fetch_arbiter`.
- `test_wrapper` gains an instance wired to a real `instruction_regfile`.

## Test plan
- After reset, `host_halt`=1, write 0xA001 to addr 3 → `host_wr_ack`=1 same cycle. Then `host_halt`=0, FSM0 requests addr 3 → `sm_gnt`=0001, next cycle `sm_rvalid`=0001 and `sm_rdata`=0xA001.
- All four FSMs request continuously for 8 cycles from `rr_ptr`=0 → grants 0,1,2,3,0,1,2,3 and exactly one `sm_rvalid` bit per cycle.
- Only FSM2 and FSM0 request, `rr_ptr`=1 → FSM2 granted first, then FSM0, then FSM2.
- In RUN, `host_halt`=1 with FSM1 requesting; `host_wr_req` is held from the cycle `host_halt` is raised:
  - FSM1 granted in that cycle, and its rvalid appears during DRAIN;
  - `halted`=1 two cycles later;
  - the held write is acked only once HALTED.
- `host_wr_req` in RUN for 5 cycles → `host_wr_ack`=0 and `write_en`=0 throughout.
- `rst`=0 asserted during a grant → next cycle `sm_rvalid`=0, `halted`=1, `rr_ptr`=0.
